// File: rtl/jam_cost_host_if.sv
// Host <-> loader/engine signal bundle for jam_cost_host.
// master: loader and engine side; slave: the host itself.
interface jam_cost_host_if;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned DATA_W  = 7;
    localparam int unsigned MC_W    = 10;
    localparam int unsigned MATCH_W = 4;
    localparam int unsigned CNT_W   = 24;

    logic               load_valid;
    logic [DATA_W-1:0]  load_data;
    logic               load_ready;
    logic               restart;
    logic               jam_rst;
    logic [IDX_W-1:0]   W;
    logic [IDX_W-1:0]   J;
    logic [DATA_W-1:0]  Cost;
    logic               Valid;
    logic [MC_W-1:0]    MinCost;
    logic [MATCH_W-1:0] MatchCount;
    logic               res_valid;
    logic [MC_W-1:0]    res_min_cost;
    logic [MATCH_W-1:0] res_match_count;
    logic [CNT_W-1:0]   res_cycles;
    logic               res_timeout;

    modport master (
        output load_valid, load_data, restart, W, J, Valid, MinCost, MatchCount,
        input  load_ready, jam_rst, Cost, res_valid, res_min_cost,
               res_match_count, res_cycles, res_timeout
    );

    modport slave (
        input  load_valid, load_data, restart, W, J, Valid, MinCost, MatchCount,
        output load_ready, jam_rst, Cost, res_valid, res_min_cost,
               res_match_count, res_cycles, res_timeout
    );
endinterface

// File: rtl/jam_cost_host.sv
// Cost-matrix host for the job-assignment engine: loads 64 costs, serves lookups, captures results.
// Optional RUN watchdog enabled by defining JAM_TIMEOUT_EN.
module jam_cost_host #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2_000_000
) (
    input  logic             CLK,
    input  logic             RST,
    jam_cost_host_if.slave   bus
);
    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned DATA_W  = 7;
    localparam int unsigned MC_W    = 10;
    localparam int unsigned MATCH_W = 4;
    localparam int unsigned CNT_W   = 24;
    localparam int unsigned DEPTH   = 64;
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    logic [DATA_W-1:0]  mem_q [DEPTH];

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic               jam_rst_q, jam_rst_d;
    logic               load_ready_q, load_ready_d;
    logic [DATA_W-1:0]  cost_q, cost_d;
    logic               res_valid_q, res_valid_d;
    logic [MC_W-1:0]    res_min_cost_q, res_min_cost_d;
    logic [MATCH_W-1:0] res_match_count_q, res_match_count_d;
    logic [CNT_W-1:0]   res_cycles_q, res_cycles_d;
    logic               res_timeout_q, res_timeout_d;
    logic               load_acc;
    logic               timeout_hit;

    assign load_acc = (state_q == ST_LOAD) && bus.load_valid;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

`ifdef JAM_TIMEOUT_EN
    // cnt_inc is the RUN-cycle count including the current cycle
    assign timeout_hit = (cnt_inc >= TIMEOUT_CYCLES);
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    // Next-state, counters and result capture
    always_comb begin
        state_d           = state_q;
        waddr_d           = waddr_q;
        cnt_d             = cnt_q;
        res_min_cost_d    = res_min_cost_q;
        res_match_count_d = res_match_count_q;
        res_cycles_d      = res_cycles_q;
        res_timeout_d     = res_timeout_q;

        case (state_q)
            ST_LOAD: begin
                cnt_d = '0;
                if (load_acc) begin
                    waddr_d = waddr_q + ADDR_W'(1);
                    if (waddr_q == LAST_ADDR) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                if (bus.Valid) begin
                    state_d           = ST_DONE;
                    res_min_cost_d    = bus.MinCost;
                    res_match_count_d = bus.MatchCount;
                    res_cycles_d      = cnt_inc;
                    res_timeout_d     = 1'b0;
                end else if (timeout_hit) begin
                    state_d           = ST_DONE;
                    res_min_cost_d    = '0;
                    res_match_count_d = '0;
                    res_cycles_d      = TIMEOUT_CYCLES;
                    res_timeout_d     = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.restart) begin
                    state_d           = ST_LOAD;
                    waddr_d           = '0;
                    res_min_cost_d    = '0;
                    res_match_count_d = '0;
                    res_cycles_d      = '0;
                    res_timeout_d     = 1'b0;
                end
            end
            default: state_d = ST_LOAD;
        endcase

        res_valid_d  = (state_d == ST_DONE);
        jam_rst_d    = (state_d != ST_RUN);
        load_ready_d = (state_d == ST_LOAD);
        cost_d       = mem_q[{bus.W, bus.J}];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q           <= ST_LOAD;
            waddr_q           <= '0;
            cnt_q             <= '0;
            jam_rst_q         <= 1'b1;
            load_ready_q      <= 1'b1;
            cost_q            <= '0;
            res_valid_q       <= 1'b0;
            res_min_cost_q    <= '0;
            res_match_count_q <= '0;
            res_cycles_q      <= '0;
            res_timeout_q     <= 1'b0;
        end else begin
            state_q           <= state_d;
            waddr_q           <= waddr_d;
            cnt_q             <= cnt_d;
            jam_rst_q         <= jam_rst_d;
            load_ready_q      <= load_ready_d;
            cost_q            <= cost_d;
            res_valid_q       <= res_valid_d;
            res_min_cost_q    <= res_min_cost_d;
            res_match_count_q <= res_match_count_d;
            res_cycles_q      <= res_cycles_d;
            res_timeout_q     <= res_timeout_d;
        end
    end

    // Matrix storage, deliberately without reset
    always_ff @(posedge CLK) begin
        if (load_acc && !RST) begin
            mem_q[waddr_q] <= bus.load_data;
        end
    end

    assign bus.load_ready      = load_ready_q;
    assign bus.jam_rst         = jam_rst_q;
    assign bus.Cost            = cost_q;
    assign bus.res_valid       = res_valid_q;
    assign bus.res_min_cost    = res_min_cost_q;
    assign bus.res_match_count = res_match_count_q;
    assign bus.res_cycles      = res_cycles_q;
    assign bus.res_timeout     = res_timeout_q;

endmodule

// File: tb/tb_jam_cost_host.sv
// Directed bench for jam_cost_host; define JAM_TIMEOUT_EN to exercise the watchdog path.
module tb_jam_cost_host;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   run_cyc;

    jam_cost_host_if bus ();

    jam_cost_host #(.TIMEOUT_CYCLES(24'd100)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Load 64 words (value i or 63-i); with gaps, idle cycles carry ignored Valid pulses
    task automatic load_matrix(input bit gaps, input bit invert);
        for (int i = 0; i < 64; i++) begin
            if (gaps) begin
                bus.load_valid = 1'b0;
                bus.Valid      = 1'b1;
                bus.MinCost    = 10'd999;
                bus.MatchCount = 4'd9;
                @(negedge clk);
                bus.Valid      = 1'b0;
            end
            if (i == 0)  check("ld_ready_first", 32'(bus.load_ready), 32'd1);
            if (i == 63) check("jam_held_last", 32'(bus.jam_rst), 32'd1);
            bus.load_valid = 1'b1;
            bus.load_data  = invert ? 7'(63 - i) : 7'(i);
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        check("ld_ready_drop", 32'(bus.load_ready), 32'd0);
        check("jam_release", 32'(bus.jam_rst), 32'd0);
        check("ld_no_result", 32'(bus.res_valid), 32'd0);
        run_cyc = 1;
    endtask

    task automatic run_until(input int n);
        while (run_cyc < n) begin
            @(negedge clk);
            run_cyc++;
        end
    endtask

    task automatic lookup(input logic [2:0] w, input logic [2:0] j, input int exp, input string tag);
        bus.W = w;
        bus.J = j;
        @(negedge clk);
        run_cyc++;
        check(tag, 32'(bus.Cost), 32'(exp));
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        @(negedge clk);
        bus.restart = 1'b0;
        check("rs_ready", 32'(bus.load_ready), 32'd1);
        check("rs_jam", 32'(bus.jam_rst), 32'd1);
        check("rs_valid", 32'(bus.res_valid), 32'd0);
        check("rs_min", 32'(bus.res_min_cost), 32'd0);
        check("rs_match", 32'(bus.res_match_count), 32'd0);
        check("rs_cycles", 32'(bus.res_cycles), 32'd0);
        check("rs_timeout", 32'(bus.res_timeout), 32'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        run_cyc = 0;
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.load_data  = '0;
        bus.restart    = 1'b0;
        bus.W          = '0;
        bus.J          = '0;
        bus.Valid      = 1'b0;
        bus.MinCost    = '0;
        bus.MatchCount = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.load_ready), 32'd1);
        check("rst_jam", 32'(bus.jam_rst), 32'd1);
        check("rst_cost", 32'(bus.Cost), 32'd0);
        check("rst_valid", 32'(bus.res_valid), 32'd0);
        check("rst_cycles", 32'(bus.res_cycles), 32'd0);
        check("rst_timeout", 32'(bus.res_timeout), 32'd0);
        rst = 1'b0;

        // Identity matrix with gaps; lookups in the first RUN cycles
        load_matrix(1'b1, 1'b0);
        lookup(3'd3, 3'd5, 29, "lk_3_5");
        lookup(3'd7, 3'd7, 63, "lk_7_7");
        lookup(3'd0, 3'd1, 1, "lk_0_1");
        check("run_jam", 32'(bus.jam_rst), 32'd0);

`ifdef JAM_TIMEOUT_EN
        run_until(100);
        check("wd_not_yet", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("wd_valid", 32'(bus.res_valid), 32'd1);
        check("wd_timeout", 32'(bus.res_timeout), 32'd1);
        check("wd_cycles", 32'(bus.res_cycles), 32'd100);
        check("wd_min", 32'(bus.res_min_cost), 32'd0);
        check("wd_jam", 32'(bus.jam_rst), 32'd1);
        do_restart();
        load_matrix(1'b0, 1'b0);
        run_until(100);
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'd142;
        bus.MatchCount = 4'd3;
        @(negedge clk);
        bus.Valid = 1'b0;
        check("wv_timeout", 32'(bus.res_timeout), 32'd0);
        check("wv_cycles", 32'(bus.res_cycles), 32'd100);
        check("wv_min", 32'(bus.res_min_cost), 32'd142);
        check("wv_match", 32'(bus.res_match_count), 32'd3);
`else
        run_until(1000);
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'd142;
        bus.MatchCount = 4'd3;
        @(negedge clk);
        bus.Valid = 1'b0;
        check("res_valid", 32'(bus.res_valid), 32'd1);
        check("res_min", 32'(bus.res_min_cost), 32'd142);
        check("res_match", 32'(bus.res_match_count), 32'd3);
        check("res_cycles", 32'(bus.res_cycles), 32'd1000);
        check("res_jam", 32'(bus.jam_rst), 32'd1);
        check("res_timeout", 32'(bus.res_timeout), 32'd0);
`endif

        // DONE: Valid and load_valid ignored, lookups still served
        bus.Valid      = 1'b1;
        bus.MinCost    = 10'd5;
        bus.MatchCount = 4'd1;
        bus.load_valid = 1'b1;
        bus.load_data  = 7'd99;
        bus.W          = 3'd7;
        bus.J          = 3'd7;
        repeat (2) @(negedge clk);
        bus.Valid      = 1'b0;
        bus.load_valid = 1'b0;
        check("done_hold_min", 32'(bus.res_min_cost), 32'd142);
        check("done_hold_match", 32'(bus.res_match_count), 32'd3);
        check("done_ready", 32'(bus.load_ready), 32'd0);
        check("done_cost", 32'(bus.Cost), 32'd63);

        // Restart, full reload of the reversed matrix starting at address 0
        do_restart();
        load_matrix(1'b0, 1'b1);
        lookup(3'd0, 3'd0, 63, "rl_0_0");
        lookup(3'd3, 3'd5, 34, "rl_3_5");
        lookup(3'd7, 3'd7, 0, "rl_7_7");

        // Reset during RUN cycle 50 aborts the run
        run_until(50);
        bus.W = 3'd0;
        bus.J = 3'd0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mr_ready", 32'(bus.load_ready), 32'd1);
        check("mr_jam", 32'(bus.jam_rst), 32'd1);
        check("mr_cost", 32'(bus.Cost), 32'd0);
        check("mr_valid", 32'(bus.res_valid), 32'd0);
        @(negedge clk);
        check("mr_cost_kept_mem", 32'(bus.Cost), 32'd63);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
